// File: rtl/vga_timing_gen_if.sv
// Raster bus between the timing generator and the flag colour generators.
// Ports: color_in (to generator), pix_x/pix_y, sync/blank strobes, frame_cnt, rgb_out.
interface vga_timing_gen_if;
   logic [5:0] color_in;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic       hsync;
   logic       vsync;
   logic       display_on;
   logic       frame_start;
   logic [7:0] frame_cnt;
   logic [5:0] rgb_out;

   modport master (
      input  color_in,
      output pix_x, pix_y, hsync, vsync,
      output display_on, frame_start, frame_cnt, rgb_out
   );

   modport slave (
      output color_in,
      input  pix_x, pix_y, hsync, vsync,
      input  display_on, frame_start, frame_cnt, rgb_out
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing source and blanked colour output stage.
// Ports: clk, rst_n (sync, active-low), vga (master: color_in in; pix_x/pix_y,
//   hsync/vsync, display_on, frame_start, frame_cnt, rgb_out out).
// Option: VGA_OUT_PIPE_EN registers rgb_out and delays all pin strobes one cycle.
module vga_timing_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic             clk,
   input  logic             rst_n,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0]  H_MAX  = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_MAX  = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS  = 11'(H_DISPLAY);
   localparam logic [10:0] V_VIS  = 11'(V_DISPLAY);
   localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] HS_END = 11'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0] VS_END = 11'(V_DISPLAY + V_FRONT + V_SYNC);

   logic       run_q;
   logic [9:0] x_q, y_q, x_nx, y_nx;
   logic [7:0] fc_q, fc_nx;
   logic       hs_q, vs_q, de_q, fs_q;
   logic       hs_nx, vs_nx, de_nx, fs_nx;
   logic [10:0] xw, yw;

   // The first clock after reset release holds (0,0) so that position
   // is presented with its strobes before the scan starts advancing.
   always_comb begin
      x_nx  = x_q;
      y_nx  = y_q;
      fc_nx = fc_q;
      if (run_q) begin
         if (x_q == H_MAX) begin
            x_nx = '0;
            if (y_q == V_MAX) begin
               y_nx  = '0;
               fc_nx = fc_q + 8'd1;
            end else begin
               y_nx = y_q + 10'd1;
            end
         end else begin
            x_nx = x_q + 10'd1;
         end
      end
   end

   // Strobes come from the next-state counters so the registered
   // versions line up with the registered pix_x/pix_y.
   assign xw = {1'b0, x_nx};
   assign yw = {1'b0, y_nx};

   always_comb begin
      hs_nx = !((xw >= HS_BEG) && (xw < HS_END));
      vs_nx = !((yw >= VS_BEG) && (yw < VS_END));
      de_nx = (xw < H_VIS) && (yw < V_VIS);
      fs_nx = (x_nx == '0) && (y_nx == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         x_q   <= '0;
         y_q   <= '0;
         fc_q  <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         de_q  <= 1'b0;
         fs_q  <= 1'b0;
      end else begin
         run_q <= 1'b1;
         x_q   <= x_nx;
         y_q   <= y_nx;
         fc_q  <= fc_nx;
         hs_q  <= hs_nx;
         vs_q  <= vs_nx;
         de_q  <= de_nx;
         fs_q  <= fs_nx;
      end
   end

   assign vga.pix_x     = x_q;
   assign vga.pix_y     = y_q;
   assign vga.frame_cnt = fc_q;

`ifdef VGA_OUT_PIPE_EN
   logic       hs_p, vs_p, de_p, fs_p;
   logic [5:0] rgb_p;

   // color_in belongs to the current pix_x/pix_y, so it is blanked with
   // the undelayed display_on and then aligned with the delayed strobes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hs_p  <= 1'b1;
         vs_p  <= 1'b1;
         de_p  <= 1'b0;
         fs_p  <= 1'b0;
         rgb_p <= '0;
      end else begin
         hs_p  <= hs_q;
         vs_p  <= vs_q;
         de_p  <= de_q;
         fs_p  <= fs_q;
         rgb_p <= de_q ? vga.color_in : 6'b000000;
      end
   end

   assign vga.hsync       = hs_p;
   assign vga.vsync       = vs_p;
   assign vga.display_on  = de_p;
   assign vga.frame_start = fs_p;
   assign vga.rgb_out     = rgb_p;
`else
   assign vga.hsync       = hs_q;
   assign vga.vsync       = vs_q;
   assign vga.display_on  = de_q;
   assign vga.frame_start = fs_q;
   assign vga.rgb_out     = de_q ? vga.color_in : 6'b000000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: full-size and shrunk-timing instances.
// Table vectors, hand sequences and an arithmetic per-cycle reference model.
module tb_vga_timing_gen;

   localparam int SHD = 4, SHF = 2, SHS = 2, SHB = 2;
   localparam int SVD = 3, SVF = 1, SVS = 1, SVB = 2;
   localparam int SHT = SHD + SHF + SHS + SHB;
   localparam int SVT = SVD + SVF + SVS + SVB;

`ifdef VGA_OUT_PIPE_EN
   localparam int OFF = 1;
`else
   localparam int OFF = 0;
`endif

   typedef struct {
      int         k;
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       de;
      logic       fs;
      logic [5:0] rgb;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_d = 1'b0;
   logic rst_s = 1'b0;

   vga_timing_gen_if vd_if ();
   vga_timing_gen_if vs_if ();

   vga_timing_gen u_def (
      .clk   (clk),
      .rst_n (rst_d),
      .vga   (vd_if.master)
   );

   vga_timing_gen #(
      .H_DISPLAY (SHD), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
      .V_DISPLAY (SVD), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB)
   ) u_small (
      .clk   (clk),
      .rst_n (rst_s),
      .vga   (vs_if.master)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // k = number of non-reset clock edges since the last reset edge.
   function automatic void ref_m(
      input int k, input int hd, hf, hs, hb, vd, vf, vs, vb,
      output logic [9:0] x, y, output logic h, v, d, f,
      output logic [7:0] fc);
      int ht, vt, t, xi, yi;
      ht = hd + hf + hs + hb;
      vt = vd + vf + vs + vb;
      if (k <= 0) begin
         x = 0; y = 0; h = 1; v = 1; d = 0; f = 0; fc = 0;
      end else begin
         t  = k - 1;
         xi = t % ht;
         yi = (t / ht) % vt;
         x  = 10'(xi);
         y  = 10'(yi);
         fc = 8'((t / (ht * vt)) % 256);
         h  = !(xi >= hd + hf && xi < hd + hf + hs);
         v  = !(yi >= vd + vf && yi < vd + vf + vs);
         d  = (xi < hd) && (yi < vd);
         f  = (xi == 0) && (yi == 0);
      end
   endfunction

   int         kd = 0, ks = 0;
   logic [5:0] cd_e, cs_e;

   always @(posedge clk) begin
      kd   <= rst_d ? kd + 1 : 0;
      ks   <= rst_s ? ks + 1 : 0;
      cd_e <= vd_if.color_in;
      cs_e <= vs_if.color_in;
   end

   task automatic chk_inst(
      input string p, input int k,
      input int hd, hf, hs, hb, vd, vf, vs, vb,
      input logic [5:0] c_now, c_edge,
      input logic [9:0] ax, ay, input logic ah, av, ad, af,
      input logic [7:0] afc, input logic [5:0] argb);
      logic [9:0] x, y, x1, y1;
      logic       h, v, d, f, h1, v1, d1, f1;
      logic [7:0] fc, fc1;
      logic [5:0] rgb;
      ref_m(k, hd, hf, hs, hb, vd, vf, vs, vb, x, y, h, v, d, f, fc);
      ref_m(k - OFF, hd, hf, hs, hb, vd, vf, vs, vb,
            x1, y1, h1, v1, d1, f1, fc1);
      rgb = d1 ? (OFF == 1 ? c_edge : c_now) : 6'b000000;
      chk({p, ".pix_x"}, ax, x);
      chk({p, ".pix_y"}, ay, y);
      chk({p, ".frame_cnt"}, afc, fc);
      chk({p, ".hsync"}, ah, h1);
      chk({p, ".vsync"}, av, v1);
      chk({p, ".display_on"}, ad, d1);
      chk({p, ".frame_start"}, af, f1);
      chk({p, ".rgb_out"}, argb, rgb);
   endtask

   vec_t obs [1024];

   always @(negedge clk) begin
      chk_inst("mdl_def", kd, 640, 16, 96, 48, 480, 10, 2, 33,
               vd_if.color_in, cd_e,
               vd_if.pix_x, vd_if.pix_y, vd_if.hsync, vd_if.vsync,
               vd_if.display_on, vd_if.frame_start,
               vd_if.frame_cnt, vd_if.rgb_out);
      chk_inst("mdl_small", ks, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB,
               vs_if.color_in, cs_e,
               vs_if.pix_x, vs_if.pix_y, vs_if.hsync, vs_if.vsync,
               vs_if.display_on, vs_if.frame_start,
               vs_if.frame_cnt, vs_if.rgb_out);
      if (kd >= 1 && kd < 1024)
         obs[kd] <= '{kd, vd_if.pix_x, vd_if.pix_y, vd_if.hsync,
                      vd_if.vsync, vd_if.display_on, vd_if.frame_start,
                      vd_if.rgb_out};
   end

   task automatic tick();
      @(posedge clk);
      #3;
      vs_if.color_in = 6'($urandom_range(0, 63));
   endtask

   localparam int NV = 10;
   vec_t tv [NV];

   initial begin
      vec_t o, q;
      bit   found;
      int   last, gap_n, vlow, n_fs;

      tv[0] = '{1,   0,   0, 1, 1, 1, 1, 6'b110000};
      tv[1] = '{2,   1,   0, 1, 1, 1, 0, 6'b110000};
      tv[2] = '{640, 639, 0, 1, 1, 1, 0, 6'b110000};
      tv[3] = '{641, 640, 0, 1, 1, 0, 0, 6'b000000};
      tv[4] = '{656, 655, 0, 1, 1, 0, 0, 6'b000000};
      tv[5] = '{657, 656, 0, 0, 1, 0, 0, 6'b000000};
      tv[6] = '{752, 751, 0, 0, 1, 0, 0, 6'b000000};
      tv[7] = '{753, 752, 0, 1, 1, 0, 0, 6'b000000};
      tv[8] = '{800, 799, 0, 1, 1, 0, 0, 6'b000000};
      tv[9] = '{801, 0,   1, 1, 1, 1, 0, 6'b110000};

      vd_if.color_in = 6'b110000;
      vs_if.color_in = 6'b000000;
      repeat (3) tick();

      chk("rst.pix_x", vd_if.pix_x, 0);
      chk("rst.pix_y", vd_if.pix_y, 0);
      chk("rst.hsync", vd_if.hsync, 1);
      chk("rst.vsync", vd_if.vsync, 1);
      chk("rst.display_on", vd_if.display_on, 0);
      chk("rst.frame_start", vd_if.frame_start, 0);
      chk("rst.frame_cnt", vd_if.frame_cnt, 0);
      chk("rst.rgb_out", vd_if.rgb_out, 0);

      rst_d = 1'b1;
      rst_s = 1'b1;
      repeat (820) tick();

      for (int i = 0; i < NV; i++) begin
         o = obs[tv[i].k];
         q = obs[tv[i].k + OFF];
         chk($sformatf("tv%0d.pix_x", i), o.x, tv[i].x);
         chk($sformatf("tv%0d.pix_y", i), o.y, tv[i].y);
         chk($sformatf("tv%0d.hsync", i), q.hs, tv[i].hs);
         chk($sformatf("tv%0d.vsync", i), q.vs, tv[i].vs);
         chk($sformatf("tv%0d.display_on", i), q.de, tv[i].de);
         chk($sformatf("tv%0d.frame_start", i), q.fs, tv[i].fs);
         chk($sformatf("tv%0d.rgb_out", i), q.rgb, tv[i].rgb);
      end

      // Mid-frame reset on the small instance at (3,2).
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (vs_if.pix_x == 3 && vs_if.pix_y == 2) found = 1;
      end
      chk("midrst.reach", found, 1);
      rst_s = 1'b0;
      tick();
      chk("midrst.pix_x", vs_if.pix_x, 0);
      chk("midrst.pix_y", vs_if.pix_y, 0);
      chk("midrst.frame_cnt", vs_if.frame_cnt, 0);
      chk("midrst.hsync", vs_if.hsync, 1);
      chk("midrst.display_on", vs_if.display_on, 0);
      chk("midrst.rgb_out", vs_if.rgb_out, 0);
      rst_s = 1'b1;
      tick();
      chk("resume.pix_x0", vs_if.pix_x, 0);
      chk("resume.pix_y0", vs_if.pix_y, 0);
      tick();
      chk("resume.pix_x1", vs_if.pix_x, 1);

      // Random colours with sporadic one-cycle resets.
      repeat (3000) begin
         rst_s = ($urandom_range(0, 99) != 0);
         tick();
      end

      // Clean run through 256 frames: pulse spacing, vsync width, wrap.
      rst_s = 1'b0;
      tick();
      rst_s = 1'b1;
      found = 0;
      last  = -1;
      gap_n = 0;
      vlow  = 0;
      n_fs  = 0;
      for (int i = 0; i < 256 * SHT * SVT + 100 && !found; i++) begin
         tick();
         if (n_fs == 1 && !vs_if.vsync) vlow++;
         if (vs_if.frame_start) begin
            if (last >= 0 && gap_n < 3) begin
               chk($sformatf("fs.gap%0d", gap_n), i - last, SHT * SVT);
               gap_n++;
            end
            if (n_fs == 1) chk("vsync.low_cycles", vlow, SHT * SVS);
            n_fs++;
            last = i;
         end
         if (vs_if.frame_cnt == 8'd255 && vs_if.pix_x == 10'(SHT - 1) &&
             vs_if.pix_y == 10'(SVT - 1)) found = 1;
      end
      chk("wrap.reach", found, 1);
      chk("wrap.fc_before", vs_if.frame_cnt, 255);
      tick();
      chk("wrap.fc_after", vs_if.frame_cnt, 0);
      chk("wrap.pix_x", vs_if.pix_x, 0);
      chk("wrap.pix_y", vs_if.pix_y, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
